// File: rtl/clock_pkg.sv
// Shared constants for the clock display path: segment patterns and digit indices.
// No logic; no latency.
// No flow control.
package clock_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [2:0] IDX_HT = 3'd0;
    localparam logic [2:0] IDX_HU = 3'd1;
    localparam logic [2:0] IDX_MT = 3'd2;
    localparam logic [2:0] IDX_MU = 3'd3;
    localparam logic [2:0] IDX_ST = 3'd4;
    localparam logic [2:0] IDX_SU = 3'd5;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD nibble to 7-segment pattern; non-decimal nibbles render as a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_to_7seg
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_OFF;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Scans a frame-coherent HH:MM:SS snapshot onto a 6-digit multiplexed 7-segment display.
// Latency: snapshot taken on the o_frame cycle; outputs are decoded from registered state.
// Backpressure: none; free-running scan, input changes wait for the next frame.
module bcd_display_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic [7:0] i_ss,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [5:0] o_dig,
    output logic       o_frame
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   snap;
    logic          frame_start;
    phase_t        phase;
    logic [3:0]    nib;
    logic          lz_blank;
    logic [6:0]    dec_seg;

    assign frame_start = (cnt == '0) && (idx == IDX_HT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt  <= '0;
            idx  <= IDX_HT;
            snap <= '0;
        end else begin
            if (frame_start) begin
                snap <= {i_hh, i_mm, i_ss};
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? IDX_HT : idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign phase = (cnt < CNT_SHOW) ? PH_BLANK : PH_SHOW;

    always_comb begin
        nib = snap[23:20];
        case (idx)
            IDX_HT:  nib = snap[23:20];
            IDX_HU:  nib = snap[19:16];
            IDX_MT:  nib = snap[15:12];
            IDX_MU:  nib = snap[11:8];
            IDX_ST:  nib = snap[7:4];
            IDX_SU:  nib = snap[3:0];
            default: nib = snap[23:20];
        endcase
    end

    // Only a true zero is suppressed; a dash in the hours-tens slot stays visible
    assign lz_blank = LZ_BLANK && (idx == IDX_HT) && (snap[23:20] == 4'd0);

    bcd_to_7seg u_dec (
        .bcd   (nib),
        .blank (lz_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        o_seg = SEG_OFF;
        o_dig = '0;
        o_dp  = 1'b0;
        if (!i_rst && phase == PH_SHOW) begin
            o_seg = dec_seg;
            o_dig = 6'd1 << idx;
            o_dp  = ((idx == IDX_HU) || (idx == IDX_MU)) && !snap[0];
        end
    end

    assign o_frame = frame_start && !i_rst;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomised scoreboard bench for bcd_display_scan: a time-based display model
// predicts every cycle's outputs for LZ_BLANK=1 and LZ_BLANK=0 instances.
module tb_bcd_display_scan;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FP = 6 * SD;

    localparam logic [6:0] DIGIT_SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_hh  = 8'h00;
    logic [7:0] i_mm  = 8'h00;
    logic [7:0] i_ss  = 8'h00;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [5:0] dig_a, dig_b;
    logic       frame_a, frame_b;

    always #5 i_clk = ~i_clk;

    bcd_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_hh(i_hh), .i_mm(i_mm), .i_ss(i_ss),
        .o_seg(seg_a), .o_dp(dp_a), .o_dig(dig_a), .o_frame(frame_a)
    );

    bcd_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b0)) dut_nlz (
        .i_clk(i_clk), .i_rst(i_rst), .i_hh(i_hh), .i_mm(i_mm), .i_ss(i_ss),
        .o_seg(seg_b), .o_dp(dp_b), .o_dig(dig_b), .o_frame(frame_b)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [6:0] seg_nlz;
        logic       dp;
        logic [5:0] dig;
        logic       frame;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    // Model: t = cycles since reset release; the displayed time is whatever was
    // applied on the frame-start cycle of the current frame.
    int          t      = 0;
    logic        m_rst  = 1'b1;
    logic [23:0] m_snap = '0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        return (n < 4'd10) ? DIGIT_SEG[n] : 7'h40;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        exp_t       e;
        int         slot;
        int         ph;
        logic [3:0] nib;
        @(posedge i_clk);
        if (m_rst) begin
            t      = 0;
            m_snap = '0;
        end else begin
            t = t + 1;
        end
        #1;
        i_rst = r;
        i_hh  = h;
        i_mm  = m;
        i_ss  = s;
        e     = '0;
        slot  = (t / SD) % 6;
        ph    = t % SD;
        if (!r) begin
            e.frame = (t % FP == 0);
            if (ph >= BL) begin
                nib       = m_snap[23 - 4*slot -: 4];
                e.dig     = 6'(1 << slot);
                e.seg_nlz = seg_of(nib);
                e.seg     = (slot == 0 && nib == 4'd0) ? 7'h00 : seg_of(nib);
                e.dp      = (slot == 1 || slot == 3) && !m_snap[0];
            end
            if (t % FP == 0) m_snap = {h, m, s};
        end
        m_rst = r;
        q.push_back(e);
    endtask

    task automatic run(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) step(1'b0, h, m, s);
    endtask

    function automatic logic [3:0] rnd_nib();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        forever begin
            @(negedge i_clk);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("seg",       8'(seg_a),   8'(mon_e.seg));
                chk("seg_nlz",   8'(seg_b),   8'(mon_e.seg_nlz));
                chk("dig",       8'(dig_a),   8'(mon_e.dig));
                chk("dig_nlz",   8'(dig_b),   8'(mon_e.dig));
                chk("dp",        8'(dp_a),    8'(mon_e.dp));
                chk("dp_nlz",    8'(dp_b),    8'(mon_e.dp));
                chk("frame",     8'(frame_a), 8'(mon_e.frame));
                chk("frame_nlz", 8'(frame_b), 8'(mon_e.frame));
                cyc++;
            end
        end
    end

    initial begin
        logic [7:0] h, m, s;
        logic       r;

        repeat (3) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        run(8'h12, 8'h34, 8'h56, 2*FP);
        run(8'h09, 8'h05, 8'h01, FP);

        // Inputs move to 12:35:00 mid-frame, during the idx3 show phase
        for (int i = 0; i < FP; i++) begin
            if (i < 3*SD + 3) step(1'b0, 8'h12, 8'h34, 8'h56);
            else              step(1'b0, 8'h12, 8'h35, 8'h00);
        end
        run(8'h12, 8'h35, 8'h00, FP);
        run(8'hF0, 8'hA3, 8'h22, FP);

        // Reset lands at idx4, cnt5
        run(8'h12, 8'h34, 8'h56, 4*SD + 5);
        step(1'b1, 8'h23, 8'h59, 8'h58);
        step(1'b1, 8'h23, 8'h59, 8'h58);
        run(8'h23, 8'h59, 8'h58, FP);

        h = {rnd_nib(), rnd_nib()};
        m = {rnd_nib(), rnd_nib()};
        s = {rnd_nib(), rnd_nib()};
        for (int i = 0; i < 20*FP; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                h = {rnd_nib(), rnd_nib()};
                m = {rnd_nib(), rnd_nib()};
                s = {rnd_nib(), rnd_nib()};
            end
            r = ($urandom_range(0, 299) == 0);
            step(r, h, m, s);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge i_clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
